// File: rtl/key_event_gen.sv
// key_event_gen: synchronize, debounce and edge/auto-repeat detect raw push-button levels
//   clk_i      system clock
//   reset_n_i  asynchronous active-low reset, released through a 2-flop bridge
//   keys_i     raw asynchronous button levels
//   keys_o     debounced levels
//   press_o    one-cycle pulse on debounced rise
//   release_o  one-cycle pulse on debounced fall
//   event_o    press_o or auto-repeat pulse
//   tick_o     one-cycle sample tick
module key_event_gen #(
  parameter int                 width_p         = 5,
  parameter int                 tick_div_p      = 781250,
  parameter int                 db_samples_p    = 3,
  parameter int                 repeat_delay_p  = 16,
  parameter int                 repeat_period_p = 4,
  parameter logic [width_p-1:0] repeat_mask_p   = 5'b01100
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] keys_i,
  output logic [width_p-1:0] keys_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o,
  output logic [width_p-1:0] event_o,
  output logic               tick_o
);
  localparam int TW = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
  localparam int DW = (db_samples_p > 1) ? $clog2(db_samples_p) : 1;
  localparam int RM = (repeat_delay_p > repeat_period_p) ? repeat_delay_p : repeat_period_p;
  localparam int RW = (RM > 1) ? $clog2(RM) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [1:0]         r_rst;
  logic               w_rst_n;
  logic [TW-1:0]      r_cnt;
  logic               w_tick;
  logic [width_p-1:0] r_s1, r_s2;

  // assertion is immediate, release waits two clean edges
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_rst <= 2'b00;
    else r_rst <= {r_rst[0], 1'b1};

  assign w_rst_n = r_rst[1];
  assign w_tick  = (r_cnt == TW'(tick_div_p - 1));
  assign tick_o  = w_tick & w_rst_n;

  always_ff @(posedge clk_i or negedge w_rst_n)
    if (!w_rst_n) begin
      r_cnt <= '0;
      r_s1  <= '0;
      r_s2  <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + TW'(1);
      r_s1  <= keys_i;
      r_s2  <= r_s1;
    end

  for (genvar k = 0; k < width_p; k++) begin : g_key
    logic          r_st, r_pr, r_rl, r_rp;
    logic [DW-1:0] r_dc;
    logic [RW-1:0] r_rc;
    state_t        r_fsm;
    logic          w_flip;
    logic [RW-1:0] w_lim;

    assign w_flip = w_tick && (r_s2[k] != r_st) && (r_dc == DW'(db_samples_p - 1));
    assign w_lim  = (r_fsm == DELAY) ? RW'(repeat_delay_p - 1) : RW'(repeat_period_p - 1);

    // a flip always wins over a due repeat, so a fall never carries a repeat pulse
    always_ff @(posedge clk_i or negedge w_rst_n)
      if (!w_rst_n) begin
        r_st  <= 1'b0;
        r_pr  <= 1'b0;
        r_rl  <= 1'b0;
        r_rp  <= 1'b0;
        r_dc  <= '0;
        r_rc  <= '0;
        r_fsm <= IDLE;
      end else begin
        r_pr <= w_flip & ~r_st;
        r_rl <= w_flip & r_st;
        r_rp <= 1'b0;
        if (w_tick) begin
          r_dc <= (r_s2[k] == r_st || w_flip) ? '0 : r_dc + DW'(1);
          if (w_flip) begin
            r_st  <= ~r_st;
            r_fsm <= (~r_st & repeat_mask_p[k]) ? DELAY : IDLE;
            r_rc  <= '0;
          end else if (r_fsm != IDLE) begin
            if (r_rc == w_lim) begin
              r_rp  <= 1'b1;
              r_fsm <= REPEAT;
              r_rc  <= '0;
            end else r_rc <= r_rc + RW'(1);
          end
        end
      end

    assign keys_o[k]    = r_st;
    assign press_o[k]   = r_pr;
    assign release_o[k] = r_rl;
    assign event_o[k]   = r_pr | r_rp;
  end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: randomized self-checking bench for key_event_gen against a tick-level behavioural model
module tb_key_event_gen;
  localparam int W = 5, DIV = 4, DB = 3, RD = 4, RP = 2;
  localparam logic [4:0] MASK = 5'b01100;

  logic       clk = 1'b0;
  logic       rn = 1'b0;
  logic [4:0] ki = '0;
  logic [4:0] keys_o, press_o, release_o, event_o;
  logic       tick_o;
  logic [20:0] w_dut;
  int checks = 0, failures = 0;

  key_event_gen #(.width_p(W), .tick_div_p(DIV), .db_samples_p(DB), .repeat_delay_p(RD),
                  .repeat_period_p(RP), .repeat_mask_p(MASK)) dut (
    .clk_i(clk), .reset_n_i(rn), .keys_i(ki), .keys_o(keys_o), .press_o(press_o),
    .release_o(release_o), .event_o(event_o), .tick_o(tick_o));

  always #5 clk = ~clk;
  assign w_dut = {keys_o, press_o, release_o, event_o, tick_o};

  logic [4:0] m_s1, m_s2, m_st, m_pr, m_rl, m_rp;
  int m_dc[5], m_n[5], m_rb, m_cnt;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_st = 0; m_pr = 0; m_rl = 0; m_rp = 0; m_rb = 0; m_cnt = 0;
    for (int k = 0; k < 5; k++) begin m_dc[k] = 0; m_n[k] = 0; end
  endtask

  function automatic logic [20:0] exp_vec();
    return {m_st, m_pr, m_rl, m_pr | m_rp, (m_rb == 2 && m_cnt == DIV - 1)};
  endfunction

  // one clock: sample inputs, advance the model by the rules, settle 1 ns past the edge
  task automatic cyc();
    logic [4:0] kp;
    logic r;
    bit t;
    kp = ki; r = rn;
    @(posedge clk);
    m_pr = 0; m_rl = 0; m_rp = 0;
    if (!r) model_clear();
    else if (m_rb < 2) m_rb++;
    else begin
      t = (m_cnt == DIV - 1);
      m_cnt = t ? 0 : m_cnt + 1;
      if (t) for (int k = 0; k < 5; k++) begin
        m_dc[k] = (m_s2[k] != m_st[k]) ? m_dc[k] + 1 : 0;
        if (m_dc[k] == DB) begin
          m_dc[k] = 0;
          m_st[k] = ~m_st[k];
          if (m_st[k]) begin m_pr[k] = 1; m_n[k] = 0; end
          else m_rl[k] = 1;
        end else if (m_st[k]) begin
          m_n[k]++;
          if (MASK[k] && m_n[k] >= RD && (m_n[k] - RD) % RP == 0) m_rp[k] = 1;
        end
      end
      m_s2 = m_s1; m_s1 = kp;
    end
    #1;
  endtask

  task automatic test_reset();
    rn = 0; ki = 5'b10101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (w_dut !== 21'd0) begin failures++; $display("FAIL reset_state got=%h exp=0", w_dut); end
    end
    rn = 1; ki = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
    end
  endtask

  task automatic test_clean_press();
    int np = 0, nr = 0;
    repeat ($urandom_range(0, 3)) cyc();
    ki[0] = 1;
    for (int i = 0; i < 100; i++) begin
      if (i == 60) ki[0] = 0;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL clean_press cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      np += press_o[0]; nr += release_o[0];
      if (event_o[0] !== press_o[0]) begin failures++; $display("FAIL clean_event cyc=%0d got=%b exp=%b", i, event_o[0], press_o[0]); end
    end
    checks += 2;
    if (np != 1) begin failures++; $display("FAIL clean_press_count got=%0d exp=1", np); end
    if (nr != 1) begin failures++; $display("FAIL clean_release_count got=%0d exp=1", nr); end
  endtask

  task automatic test_bounce();
    int np = 0;
    for (int i = 0; i < 120; i++) begin
      ki[1] = (i < 80) ? ((i / 5) % 2 == 0) : 1'b0;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL bounce cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      np += press_o[1] | event_o[1] | keys_o[1];
    end
    checks++;
    if (np != 0) begin failures++; $display("FAIL bounce_activity got=%0d exp=0", np); end
  endtask

  task automatic test_auto_repeat();
    int ne = 0, me = 0, hold;
    hold = 60 + $urandom_range(0, 40);
    ki[3] = 1;
    for (int i = 0; i < hold + 40; i++) begin
      if (i == hold) ki[3] = 0;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL auto_repeat cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      ne += event_o[3]; me += m_pr[3] | m_rp[3];
      if (release_o[3] && event_o[3]) begin failures++; $display("FAIL repeat_on_release cyc=%0d got=1 exp=0", i); end
    end
    checks++;
    if (ne != me || me < 2) begin failures++; $display("FAIL repeat_count got=%0d exp=%0d", ne, me); end
  endtask

  task automatic test_unmasked_hold();
    int ne = 0;
    ki[1] = 1;
    for (int i = 0; i < 140; i++) begin
      if (i == 100) ki[1] = 0;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL unmasked cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      ne += event_o[1];
    end
    checks++;
    if (ne != 1) begin failures++; $display("FAIL unmasked_events got=%0d exp=1", ne); end
  endtask

  task automatic test_reset_mid_repeat();
    int np = 0;
    ki[2] = 1;
    for (int i = 0; i < 45 + $urandom_range(0, 7); i++) begin
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
    end
    rn = 0;
    #1;
    model_clear();
    checks++;
    if (w_dut !== 21'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", w_dut); end
    repeat (2) cyc();
    rn = 1;
    for (int i = 0; i < 90; i++) begin
      if (i == 70) ki[2] = 0;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      np += press_o[2];
    end
    checks++;
    if (np != 1) begin failures++; $display("FAIL post_reset_press got=%0d exp=1", np); end
  endtask

  task automatic test_simultaneous();
    int last = -1, np = 0;
    ki[3:2] = 2'b11;
    for (int i = 0; i < 80; i++) begin
      if (i == 50) ki[3:2] = 2'b00;
      cyc();
      checks++;
      if (w_dut !== exp_vec()) begin failures++; $display("FAIL simultaneous cyc=%0d got=%h exp=%h", i, w_dut, exp_vec()); end
      if (press_o != 0) begin
        np++;
        checks++;
        if (press_o !== 5'b01100) begin failures++; $display("FAIL simul_press got=%b exp=01100", press_o); end
      end
      if (tick_o) begin
        if (last >= 0) begin
          checks++;
          if (i - last != DIV) begin failures++; $display("FAIL tick_period got=%0d exp=%0d", i - last, DIV); end
        end
        last = i;
      end
    end
    checks++;
    if (np != 1) begin failures++; $display("FAIL simul_press_cycles got=%0d exp=1", np); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 16; s++) begin
      ki = 5'($urandom);
      for (int i = 0; i < $urandom_range(2, 50); i++) begin
        if ($urandom_range(0, 9) == 0) ki[$urandom_range(0, 4)] ^= 1'b1;
        cyc();
        checks++;
        if (w_dut !== exp_vec()) begin failures++; $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", s, i, w_dut, exp_vec()); end
      end
    end
    ki = 0;
    repeat (30) cyc();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_unmasked_hold();
    test_reset_mid_repeat();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
